mem_access_unit: RTL
====================

Name: mem_access_unit

Overview:
- Initiator side of the unified instruction/data memory port in the multi-cycle MIPS core.
- Accepts load/store requests from the datapath using byte addresses and byte, half or word size.
- Drives the word-indexed memory port (addr, we, wd), reads the combinational rd, and performs read-modify-write for sub-word stores.
- Returns sign- or zero-extended load data, with error reporting for misaligned, out-of-range and instruction-region-store accesses.

Parameters:
INSTR_MEM_SIZE, 32, number of instruction words at word indices 0..INSTR_MEM_SIZE-1
DATA_MEM_SIZE, 32, number of data words following the instruction region
PROTECT_INSTR, 1, when 1, stores to the instruction region are rejected with an error

Ports:
clk  in  1  clock
rstn  in  1  synchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  unit can accept a request; equals (state==IDLE)
req_we  in  1  1=store, 0=load
req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
req_signed  in  1  sign-extend sub-word loads
req_addr  in  32  byte address
req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
resp_valid  out  1  one-cycle response pulse
resp_rdata  out  32  extended load data; 0 for stores and errors
resp_err  out  1  request rejected, valid with resp_valid
mem_addr  out  32  word index to memory (req_addr>>2, latched)
mem_we  out  1  memory write enable
mem_wd  out  32  memory write data
mem_rd  in  32  memory combinational read data

Behaviour:
- Reset: rstn sampled low at a clk edge puts the unit in state IDLE and drives outputs as follows:
  - resp_valid=0, resp_rdata=0, resp_err=0
  - mem_addr=0, mem_wd=0, mem_we=0
  - Any in-flight request is dropped with no response and no write.
  - The memory clears its data region on the same reset.
- Handshake: a request is accepted at the edge where req_valid && req_ready. Request fields are latched at that edge. No response back-pressure.
- Lane mapping is little-endian: byte k = bits [8k+7:8k] with k = addr[1:0]; half at addr[1]=h is bits [16h+15:16h].
- Error check, evaluated on the request fields at acceptance. Any of the following is an error:
  - size 11
  - half with addr[0]=1
  - word with addr[1:0]!=0
  - word index >= INSTR_MEM_SIZE+DATA_MEM_SIZE
  - store with index < INSTR_MEM_SIZE when PROTECT_INSTR=1
- States: IDLE, RD, WR, RESP.
  - IDLE -> RESP on error.
  - IDLE -> WR on a word store.
  - IDLE -> RD on a load or sub-word store.
  - RD: mem_addr holds the latched index; mem_rd is captured into a word register at the end of the cycle. RD -> RESP for a load, RD -> WR for a store.
  - WR: mem_we=1 for exactly this one cycle. mem_wd is the full store word (word store) or the captured word with only the addressed lanes replaced (sub-word store). WR -> RESP.
  - RESP: resp_valid=1 for one cycle, then -> IDLE.
- Response data:
  - Load: extracted lane, sign-extended if req_signed else zero-extended. Word loads are passed through.
  - Store or error: resp_rdata=0.
  - resp_err=1 only on error.
- Latency, counted from the acceptance edge to resp_valid high:
  - load: 2 cycles
  - word store: 2 cycles
  - sub-word store: 3 cycles
  - error: 1 cycle
- mem_we is never asserted outside WR and never asserted for an error request.
- mem_addr stays stable from acceptance through RESP. req_ready is low from the acceptance edge until RESP has completed.
- Back-to-back: the next request can be accepted at the edge ending RESP + 1, i.e. the first cycle the unit is back in IDLE.

Test Plan:
1. Word store 0xDEADBEEF to 0x84, then word load 0x84 -> memory word 33 = 0xDEADBEEF; mem_we high exactly 1 cycle; each response arrives 2 cycles after acceptance; load resp_rdata=0xDEADBEEF, resp_err=0.
2. Word 0x11223344 at 0x84, then byte store 0xA5 to 0x86 -> word 33 = 0x11A53344, RD-WR-RESP sequence. Signed byte load 0x86 -> 0xFFFFFFA5; unsigned -> 0x000000A5.
3. Word 0x80001234 at 0x88 -> signed half load 0x8A returns 0xFFFF8000; unsigned half load 0x88 returns 0x00001234; half store 0xBEEF to 0x88 gives word 0x8000BEEF.
4. Errors, each with resp_err=1, resp_rdata=0, mem_we never high, 1-cycle latency:
   - word load 0x82
   - half load 0x85
   - size 11
   - word store to 0x10 (word 4 unchanged)
   - load from 0x100 (index 64)
5. Reset mid-operation: rstn=0 for one edge while in RD of a byte store -> no mem_we, no resp_valid; req_ready=1 after release; data region reads 0.
6. req_valid held high with two queued loads -> the second is accepted only once the unit is back in IDLE; req_ready low for 2 cycles between acceptances; two resp_valid pulses, in order, with correct data.

Source files
------------

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - load/store initiator for the unified MIPS memory port
//
// Purpose:
//   Takes byte-addressed load/store requests of byte, half or word size from
//   the datapath. Drives the word-indexed memory port and reads its
//   combinational read data. Sub-word stores are done as read-modify-write.
//   Load data is returned sign- or zero-extended. Misaligned, out-of-range,
//   illegal-size and (optionally) instruction-region stores are rejected
//   with resp_err.
//
// Ports:
//   clk, rstn      clock, synchronous active-low reset
//   req_valid      request present
//   req_ready      unit is idle and accepts a request this cycle
//   req_we         1 = store, 0 = load
//   req_size       00 byte, 01 half, 10 word, 11 illegal
//   req_signed     sign-extend sub-word load data
//   req_addr       byte address
//   req_wdata      right-aligned store data
//   resp_valid     one-cycle response pulse
//   resp_rdata     extended load data, 0 for stores and errors
//   resp_err       request rejected (valid with resp_valid)
//   mem_addr       word index to memory, held for the whole request
//   mem_we         memory write enable (one cycle, WR state only)
//   mem_wd         memory write data
//   mem_rd         memory combinational read data

module mem_access_unit #(
  parameter int INSTR_MEM_SIZE = 32,
  parameter int DATA_MEM_SIZE  = 32,
  parameter bit PROTECT_INSTR  = 1'b1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_BAD  = 2'b11;

  localparam logic [31:0] INSTR_LIMIT = 32'(INSTR_MEM_SIZE);
  localparam logic [31:0] MEM_LIMIT   = 32'(INSTR_MEM_SIZE + DATA_MEM_SIZE);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RD   = 2'b01,
    S_WR   = 2'b10,
    S_RESP = 2'b11
  } state_t;

  state_t      state_q;
  logic [31:0] mem_addr_q;
  logic        mem_we_q;
  logic [31:0] mem_wd_q;
  logic        resp_valid_q;
  logic [31:0] resp_rdata_q;
  logic        resp_err_q;

  // Request fields latched at acceptance
  logic        we_q;
  logic [1:0]  size_q;
  logic        signed_q;
  logic [1:0]  lane_q;
  logic [31:0] wdata_q;

  logic [31:0] req_idx;
  logic        req_err;

  // Replace only the addressed lanes of a word with right-aligned store data.
  function automatic logic [31:0] lane_merge(input logic [31:0] word,
                                             input logic [31:0] wdata,
                                             input logic [1:0]  size,
                                             input logic [1:0]  lane);
    logic [31:0] r;
    r = word;
    case (size)
      SZ_BYTE: r[{lane, 3'b000} +: 8]     = wdata[7:0];
      SZ_HALF: r[{lane[1], 4'b0000} +: 16] = wdata[15:0];
      default: r = wdata;
    endcase
    return r;
  endfunction

  // Pull the addressed lane out of a word and extend it to 32 bits.
  function automatic logic [31:0] lane_extract(input logic [31:0] word,
                                               input logic [1:0]  size,
                                               input logic [1:0]  lane,
                                               input logic        sgn);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{lane, 3'b000} +: 8];
    h = word[{lane[1], 4'b0000} +: 16];
    case (size)
      SZ_BYTE: r = {{24{sgn & b[7]}}, b};
      SZ_HALF: r = {{16{sgn & h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  // Error classification uses the live request fields so the decision is
  // made in the acceptance cycle.
  always_comb begin
    req_idx = {2'b00, req_addr[31:2]};
    req_err = 1'b0;
    if (req_size == SZ_BAD)                               req_err = 1'b1;
    if (req_size == SZ_HALF && req_addr[0])               req_err = 1'b1;
    if (req_size == SZ_WORD && req_addr[1:0] != 2'b00)    req_err = 1'b1;
    if (req_idx >= MEM_LIMIT)                             req_err = 1'b1;
    if (PROTECT_INSTR && req_we && req_idx < INSTR_LIMIT) req_err = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= S_IDLE;
      mem_addr_q   <= 32'h0;
      mem_we_q     <= 1'b0;
      mem_wd_q     <= 32'h0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'h0;
      resp_err_q   <= 1'b0;
      we_q         <= 1'b0;
      size_q       <= SZ_BYTE;
      signed_q     <= 1'b0;
      lane_q       <= 2'b00;
      wdata_q      <= 32'h0;
    end else begin
      // Pulsed outputs default low; each state raises them for one cycle.
      mem_we_q     <= 1'b0;
      resp_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            mem_addr_q   <= req_idx;
            we_q         <= req_we;
            size_q       <= req_size;
            signed_q     <= req_signed;
            lane_q       <= req_addr[1:0];
            wdata_q      <= req_wdata;
            resp_rdata_q <= 32'h0;
            resp_err_q   <= 1'b0;
            if (req_err) begin
              state_q      <= S_RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
            end else if (req_we && req_size == SZ_WORD) begin
              // Full-word store needs no read: write straight away.
              state_q  <= S_WR;
              mem_we_q <= 1'b1;
              mem_wd_q <= req_wdata;
            end else begin
              state_q <= S_RD;
            end
          end
        end
        S_RD: begin
          if (we_q) begin
            state_q  <= S_WR;
            mem_we_q <= 1'b1;
            mem_wd_q <= lane_merge(mem_rd, wdata_q, size_q, lane_q);
          end else begin
            state_q      <= S_RESP;
            resp_valid_q <= 1'b1;
            resp_rdata_q <= lane_extract(mem_rd, size_q, lane_q, signed_q);
          end
        end
        S_WR: begin
          state_q      <= S_RESP;
          resp_valid_q <= 1'b1;
          resp_rdata_q <= 32'h0;
        end
        default: begin
          // S_RESP: clear response fields so they read 0 while idle.
          state_q      <= S_IDLE;
          resp_rdata_q <= 32'h0;
          resp_err_q   <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign mem_addr   = mem_addr_q;
  assign mem_we     = mem_we_q;
  assign mem_wd     = mem_wd_q;

endmodule
